// File: rtl/ifu_axi_fetch.sv
// ifu_axi_fetch: single-outstanding instruction fetch over an AXI4-lite style read channel,
// delivering one instruction per execute-stage request.
module ifu_axi_fetch #(
    parameter int                   ISA_WIDTH = 64,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = 64'h80000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ifetch_req,
    input  logic                 ifetch_taken,
    input  logic [ISA_WIDTH-1:0] ifetch_taken_pc,
    output logic                 IFU_vld,
    output logic [ISA_WIDTH-1:0] IFU_pc,
    output logic [ISA_WIDTH-1:0] IFU_inst,
    output logic [ISA_WIDTH-1:0] axi_AR_ADDR,
    output logic                 axi_AR_VALID,
    input  logic                 axi_AR_READY,
    input  logic [ISA_WIDTH-1:0] axi_R_DATA,
    input  logic                 axi_R_VALID,
    output logic                 axi_R_READY
);
    typedef enum logic [1:0] {S_AR, S_R, S_WAIT} state_t;
    state_t               state, state_n;
    logic [ISA_WIDTH-1:0] pc, pc_n, ipc_n, inst_n;
    logic                 vld_n, armed;
    logic [31:0]          word;
    // armed keeps AR_VALID low while in reset even though the reset state is S_AR
    assign axi_AR_VALID = armed && state == S_AR;
    assign axi_AR_ADDR  = axi_AR_VALID ? {pc[ISA_WIDTH-1:3], 3'b0} : '0;
    assign axi_R_READY  = state == S_R;
    assign word         = pc[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_AR;
            pc       <= RESET_PC;
            armed    <= 1'b0;
            IFU_vld  <= 1'b0;
            IFU_pc   <= RESET_PC;
            IFU_inst <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            armed    <= 1'b1;
            IFU_vld  <= vld_n;
            IFU_pc   <= ipc_n;
            IFU_inst <= inst_n;
        end
    end
    always_comb begin
        state_n = state;
        pc_n    = pc;
        vld_n   = 1'b0;
        ipc_n   = IFU_pc;
        inst_n  = IFU_inst;
        case (state)
            S_AR: state_n = (axi_AR_VALID && axi_AR_READY) ? S_R : S_AR;
            S_R: begin
                if (axi_R_VALID) begin
                    state_n = S_WAIT;
                    vld_n   = 1'b1;
                    ipc_n   = pc;
                    inst_n  = {{(ISA_WIDTH-32){1'b0}}, word};
                end
            end
            S_WAIT: begin
                if (ifetch_req) begin
                    state_n = S_AR;
                    pc_n    = ifetch_taken ? ifetch_taken_pc : pc + ISA_WIDTH'(4);
                end
            end
            default: state_n = S_AR;
        endcase
    end
endmodule
